// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver.
//   state_t     : receiver FSM states
//   DEFAULT_*   : default parameter values for the top
//   SAMPLE_OFS  : distance (in ticks) of the outer majority samples from mid-bit
//   majority3() : 2-of-3 vote
package uart_rx_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH     = 8;
    localparam int unsigned DEFAULT_PRESCALE_WIDTH = 5;
    localparam int unsigned SAMPLE_OFS             = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Captures RX_IN at ticks mid-1, mid and mid+1 of the current bit and
// presents their 2-of-3 majority.
//   clk, rst_n : clock, async active-low reset
//   rx_in      : serial line
//   active     : high while a frame is being received
//   mid        : PRESCALE/2 for the frame in progress
//   tick       : tick position within the current bit
//   maj_c      : combinational majority of the three captured samples; valid
//                from tick mid+2 to the end of the bit
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx_in,
    input  logic                      active,
    input  logic [PRESCALE_WIDTH-1:0] mid,
    input  logic [PRESCALE_WIDTH-1:0] tick,
    output logic                      maj_c
);

    logic s_early;
    logic s_mid;
    logic s_late;

    // Sample capture; each bit overwrites all three before the vote is used
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_early <= 1'b0;
            s_mid   <= 1'b0;
            s_late  <= 1'b0;
        end else if (active) begin
            if (tick == mid - PRESCALE_WIDTH'(SAMPLE_OFS)) s_early <= rx_in;
            if (tick == mid)                               s_mid   <= rx_in;
            if (tick == mid + PRESCALE_WIDTH'(SAMPLE_OFS)) s_late  <= rx_in;
        end
    end

    assign maj_c = majority3(s_early, s_mid, s_late);

endmodule

// File: rtl/uart_rx_top.sv
// UART receiver: start bit, DATA_WIDTH data bits LSB first, optional parity,
// one stop bit, PRESCALE clock cycles per bit with 3-sample majority voting.
//   CLK        : clock (rising edge)
//   RST        : async active-low reset
//   RX_IN      : serial line, idles high
//   PRESCALE   : cycles per bit (even, 6..30), captured while idle
//   PAR_EN     : parity bit present, captured while idle
//   PAR_TYP    : 0 even / 1 odd parity, captured while idle
//   P_DATA     : last correctly received word
//   DATA_VALID : one-cycle pulse when P_DATA is updated
module uart_rx_top
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int unsigned PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      DATA_VALID
);

    localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    state_t                      state_q;
    state_t                      state_d;
    logic [PRESCALE_WIDTH-1:0]   tick_q;
    logic [BIT_CNT_W-1:0]        bit_cnt_q;
    logic [DATA_WIDTH-1:0]       shift_q;
    logic                        par_err_q;
    logic [PRESCALE_WIDTH-1:0]   prescale_q;
    logic                        par_en_q;
    logic                        par_typ_q;
    logic                        rx_prev_q;

    logic                        maj_c;
    logic [PRESCALE_WIDTH-1:0]   mid_c;
    logic                        start_c;
    logic                        last_tick_c;
    logic                        last_bit_c;
    logic                        par_bad_c;
    logic                        frm_err_c;
    logic                        frame_ok_c;

    // A start needs a genuine falling edge, so a line held low across reset is ignored
    assign start_c     = (state_q == IDLE) && rx_prev_q && !RX_IN;
    assign mid_c       = prescale_q >> 1;
    assign last_tick_c = (tick_q == prescale_q - PRESCALE_WIDTH'(1));
    assign last_bit_c  = (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1));
    assign par_bad_c   = ((^shift_q) ^ maj_c) != par_typ_q;
    assign frm_err_c   = !maj_c;
    assign frame_ok_c  = !frm_err_c && !par_err_q;

    uart_rx_sampler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_sampler (
        .clk    (CLK),
        .rst_n  (RST),
        .rx_in  (RX_IN),
        .active (state_q != IDLE),
        .mid    (mid_c),
        .tick   (tick_q),
        .maj_c  (maj_c)
    );

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; every transition out of a bit happens on its last tick
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_c) state_d = START;
            START:   if (last_tick_c) state_d = maj_c ? IDLE : DATA;
            DATA:    if (last_tick_c && last_bit_c) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (last_tick_c) state_d = STOP;
            STOP:    if (last_tick_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters, deserializer, checkers and output register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tick_q     <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            rx_prev_q  <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
        end else begin
            rx_prev_q  <= RX_IN;
            DATA_VALID <= 1'b0;

            if (state_q == IDLE) begin
                prescale_q <= PRESCALE;
                par_en_q   <= PAR_EN;
                par_typ_q  <= PAR_TYP;
                bit_cnt_q  <= '0;
                // The detection cycle is tick 0 of the start bit
                tick_q     <= start_c ? PRESCALE_WIDTH'(1) : '0;
                if (start_c) par_err_q <= 1'b0;
            end else begin
                tick_q <= last_tick_c ? '0 : tick_q + PRESCALE_WIDTH'(1);
            end

            if (state_q == DATA && last_tick_c) begin
                shift_q   <= {maj_c, shift_q[DATA_WIDTH-1:1]};
                bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
            end

            if (state_q == PARITY && last_tick_c) par_err_q <= par_bad_c;

            if (state_q == STOP && last_tick_c && frame_ok_c) begin
                P_DATA     <= shift_q;
                DATA_VALID <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_top.sv
// Directed bench for uart_rx_top: good frames (even/odd/no parity, back-to-back),
// parity and framing errors, start glitch, sample-point glitch at PRESCALE=16,
// mid-frame configuration change and mid-frame reset.
module tb_uart_rx_top;

    localparam int unsigned DW = 8;
    localparam int unsigned PW = 5;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RX_IN = 1'b1;
    logic [PW-1:0] PRESCALE;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int vld_cnt  = 0;

    always #5 CLK = ~CLK;

    uart_rx_top #(
        .DATA_WIDTH     (DW),
        .PRESCALE_WIDTH (PW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PRESCALE   (PRESCALE),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID)
    );

    // Counts cycles with DATA_VALID high; one per good frame if pulses are one cycle wide
    always @(negedge CLK) begin
        if (DATA_VALID === 1'b1) vld_cnt <= vld_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Wait n rising edges, then settle 1 time unit past the edge
    task automatic tick_wait(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // One bit of p cycles; the line is inverted during tick gl (gl < 0: none)
    task automatic drive_bit(input logic v, input int p, input int gl);
        for (int t = 0; t < p; t++) begin
            RX_IN = (t == gl) ? ~v : v;
            @(posedge CLK);
            #1;
        end
    endtask

    // Full frame; returns 1 time unit after the edge that ends the stop bit
    task automatic send_frame(input logic [7:0] d, input int p, input bit use_par,
                              input logic par, input logic stop,
                              input int gl_bit, input int gl_tick);
        drive_bit(1'b0, p, -1);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p, (i == gl_bit) ? gl_tick : -1);
        if (use_par) drive_bit(par, p, -1);
        drive_bit(stop, p, -1);
        RX_IN = 1'b1;
    endtask

    initial begin
        PRESCALE = 5'd8;
        PAR_EN   = 1'b1;
        PAR_TYP  = 1'b0;
        tick_wait(3);
        check("rst_p_data", 32'(P_DATA), 32'h0);
        check("rst_valid", 32'(DATA_VALID), 32'h0);
        RST = 1'b1;
        tick_wait(3);

        // 0xA9 has four ones: even parity bit 0
        send_frame(8'hA9, 8, 1'b1, 1'b0, 1'b1, -1, -1);
        check("a9_valid", 32'(DATA_VALID), 32'h1);
        check("a9_data", 32'(P_DATA), 32'hA9);

        // 0xAB has five ones: odd parity bit 0; start follows the stop bit directly
        PAR_TYP = 1'b1;
        send_frame(8'hAB, 8, 1'b1, 1'b0, 1'b1, -1, -1);
        check("ab_valid", 32'(DATA_VALID), 32'h1);
        check("ab_data", 32'(P_DATA), 32'hAB);
        tick_wait(1);
        check("ab_pulse_end", 32'(DATA_VALID), 32'h0);
        tick_wait(4);
        check("pulses_after_ab", 32'(vld_cnt), 32'd2);

        // No parity; configuration changes mid-frame must be ignored
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
        fork
            send_frame(8'hE9, 8, 1'b0, 1'b0, 1'b1, -1, -1);
            begin
                tick_wait(20);
                PRESCALE = 5'd16;
                PAR_EN   = 1'b1;
                PAR_TYP  = 1'b1;
            end
        join
        check("e9_valid", 32'(DATA_VALID), 32'h1);
        check("e9_data", 32'(P_DATA), 32'hE9);
        PRESCALE = 5'd8;
        PAR_EN   = 1'b1;
        PAR_TYP  = 1'b0;
        tick_wait(4);
        check("pulses_after_e9", 32'(vld_cnt), 32'd3);

        // 0x55 has four ones: parity bit 1 is wrong for even parity
        send_frame(8'h55, 8, 1'b1, 1'b1, 1'b1, -1, -1);
        check("par_err_valid", 32'(DATA_VALID), 32'h0);
        check("par_err_data", 32'(P_DATA), 32'hE9);
        tick_wait(4);
        // Correct parity, stop bit 0
        send_frame(8'h55, 8, 1'b1, 1'b0, 1'b0, -1, -1);
        check("frm_err_valid", 32'(DATA_VALID), 32'h0);
        check("frm_err_data", 32'(P_DATA), 32'hE9);
        tick_wait(4);
        check("pulses_after_errs", 32'(vld_cnt), 32'd3);

        // Two-cycle low glitch, then a good frame proves the FSM is back in IDLE
        RX_IN = 1'b0;
        tick_wait(2);
        RX_IN = 1'b1;
        tick_wait(20);
        check("glitch_pulses", 32'(vld_cnt), 32'd3);
        check("glitch_data", 32'(P_DATA), 32'hE9);
        send_frame(8'h96, 8, 1'b1, 1'b0, 1'b1, -1, -1);
        check("96_valid", 32'(DATA_VALID), 32'h1);
        check("96_data", 32'(P_DATA), 32'h96);
        tick_wait(4);
        check("pulses_after_96", 32'(vld_cnt), 32'd4);

        // PRESCALE=16 (samples at ticks 7,8,9): flip data bit 2 at tick 9
        PRESCALE = 5'd16;
        PAR_EN   = 1'b0;
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b1, 2, 9);
        check("3c_valid", 32'(DATA_VALID), 32'h1);
        check("3c_data", 32'(P_DATA), 32'h3C);
        tick_wait(4);

        // Reset mid-frame, release with the line still low: no frame may start
        RX_IN = 1'b0;
        tick_wait(40);
        RST = 1'b0;
        #1;
        check("midrst_data", 32'(P_DATA), 32'h0);
        check("midrst_valid", 32'(DATA_VALID), 32'h0);
        tick_wait(2);
        RST = 1'b1;
        tick_wait(60);
        RX_IN = 1'b1;
        tick_wait(200);
        check("midrst_no_frame", 32'(vld_cnt), 32'd5);
        check("midrst_data_held", 32'(P_DATA), 32'h0);

        // Reception resumes on the next falling edge
        PRESCALE = 5'd8;
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, -1, -1);
        check("5a_valid", 32'(DATA_VALID), 32'h1);
        check("5a_data", 32'(P_DATA), 32'h5A);
        tick_wait(4);
        check("pulses_final", 32'(vld_cnt), 32'd6);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
